// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback, drives datapath strobes, retires instructions.
// Latency: branch/fence/system 3, ALU 4, store 4, load 5 cycles with ready high; imem/dmem ready stalls with a watchdog to FAULT.
// Optional trap path is enabled by defining MULTICYCLE_CTRL_TRAP_EN (illegal class and SYSTEM go to TRAP instead of FAULT/NOP).
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_r_type,
    input  logic                 is_i_type,
    input  logic                 is_s_type,
    input  logic                 is_b_type,
    input  logic                 is_u_type,
    input  logic                 is_j_type,
    input  logic                 is_fence_type,
    input  logic                 is_system_type,
    input  logic                 is_load,
    input  logic                 is_jalr,
    input  logic                 branch_taken,
    output logic                 imem_req,
    input  logic                 imem_ready,
    output logic                 ir_we,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ready,
    output logic                 alu_src_b,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 retire,
    output logic                 trap,
    output logic                 fault,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

`ifdef MULTICYCLE_CTRL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd6,
        S_FAULT   = 3'd7
    } state_e;

    typedef struct packed {
        logic r;
        logic i;
        logic s;
        logic b;
        logic u;
        logic j;
        logic fence;
        logic sys;
        logic load;
        logic jalr;
    } cls_t;

    state_e               state_q, state_d;
    cls_t                 cls_q, cls_d;
    logic [CNT_W-1:0]     wd_q, wd_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    logic [7:0] cls_vec;
    logic       is_ld_q;
    logic       is_jr_q;
    logic       waiting;
    logic       wd_hit;

    assign cls_vec = {is_r_type, is_i_type, is_s_type, is_b_type,
                      is_u_type, is_j_type, is_fence_type, is_system_type};
    assign is_ld_q = cls_q.i & cls_q.load;
    assign is_jr_q = cls_q.i & cls_q.jalr;

    // Ready landing in the cycle the limit is reached wins over the watchdog.
    assign waiting = ((state_q == S_FETCH) & ~imem_ready) |
                     ((state_q == S_MEM)   & ~dmem_ready);
    assign wd_hit  = (MEM_TIMEOUT != 0) && waiting && (wd_q == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cls_q     <= '0;
            wd_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wd_q      <= wd_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_src_b = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        retire    = 1'b0;
        trap      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wd_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                cls_d = {cls_vec, is_load, is_jalr};
                if ($onehot(cls_vec)) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = TRAP_EN ? S_TRAP : S_FAULT;
                end
            end
            S_EXECUTE: begin
                alu_src_b = cls_q.i | cls_q.s | cls_q.u | cls_q.j;
                if (cls_q.b) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? 2'd1 : 2'd0;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_ld_q || cls_q.s) begin
                    state_d = S_MEM;
                end else if (TRAP_EN && cls_q.sys) begin
                    state_d = S_TRAP;
                end else if (cls_q.fence || cls_q.sys) begin
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (cls_q.r || cls_q.i || cls_q.u || cls_q.j) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls_q.s;
                if (dmem_ready) begin
                    if (cls_q.s) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wd_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                wb_sel  = (cls_q.j || is_jr_q) ? 2'd2 : (is_ld_q ? 2'd1 : 2'd0);
                pc_sel  = cls_q.j ? 2'd1 : (is_jr_q ? 2'd2 : 2'd0);
                state_d = S_FETCH;
            end
            S_TRAP: begin
                trap    = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = 2'd3;
                state_d = S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // Watchdog restarts whenever a new fetch or memory wait begins.
    always_comb begin
        wd_d = wd_q;
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
            wd_d = '0;
        end else if ((MEM_TIMEOUT != 0) && waiting) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    assign state   = state_q;
    assign fault   = (state_q == S_FAULT);
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes hand-computed per-cycle expectations, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_r_type, is_i_type, is_s_type, is_b_type;
    logic        is_u_type, is_j_type, is_fence_type, is_system_type;
    logic        is_load, is_jalr, branch_taken;
    logic        imem_req, imem_ready, ir_we;
    logic        dmem_req, dmem_we, dmem_ready;
    logic        alu_src_b, rf_we, pc_we, retire, trap, fault;
    logic [1:0]  wb_sel, pc_sel;
    logic [2:0]  state;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .INSTRET_W(32)) dut (
        .clk(clk), .rst(rst),
        .is_r_type(is_r_type), .is_i_type(is_i_type), .is_s_type(is_s_type),
        .is_b_type(is_b_type), .is_u_type(is_u_type), .is_j_type(is_j_type),
        .is_fence_type(is_fence_type), .is_system_type(is_system_type),
        .is_load(is_load), .is_jalr(is_jalr), .branch_taken(branch_taken),
        .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .alu_src_b(alu_src_b), .rf_we(rf_we), .wb_sel(wb_sel),
        .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire), .trap(trap),
        .fault(fault), .state(state), .instret(instret)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       ireq;
        logic       irwe;
        logic       dreq;
        logic       dwe;
        logic       asb;
        logic       rfwe;
        logic [1:0] wbs;
        logic       pcwe;
        logic [1:0] pcs;
        logic       ret;
        logic       trp;
        logic       flt;
    } obs_t;

    typedef struct packed {
        obs_t        o;
        logic [31:0] n;
    } exp_t;

    // {r,i,s,b,u,j,fence,sys,load,jalr}
    localparam logic [9:0] FL_NONE = 10'b0000000000;
    localparam logic [9:0] FL_R    = 10'b1000000000;
    localparam logic [9:0] FL_I    = 10'b0100000000;
    localparam logic [9:0] FL_LD   = 10'b0100000010;
    localparam logic [9:0] FL_JALR = 10'b0100000001;
    localparam logic [9:0] FL_S    = 10'b0010000000;
    localparam logic [9:0] FL_B    = 10'b0001000000;
    localparam logic [9:0] FL_U    = 10'b0000100000;
    localparam logic [9:0] FL_J    = 10'b0000010000;
    localparam logic [9:0] FL_F    = 10'b0000001000;
    localparam logic [9:0] FL_SYS  = 10'b0000000100;
    localparam logic [9:0] FL_RI   = 10'b1100000000;

    exp_t        q[$];
    string       nq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret = 32'd0;
    obs_t        act;
    exp_t        me;
    string       mn;

    assign act = {state, imem_req, ir_we, dmem_req, dmem_we, alu_src_b, rf_we,
                  wb_sel, pc_we, pc_sel, retire, trap, fault};

    function automatic obs_t ob(input logic [2:0] st, input logic ireq, irwe, dreq, dwe,
                                input logic asb, rfwe, input logic [1:0] wbs,
                                input logic pcwe, input logic [1:0] pcs,
                                input logic ret, trp, flt);
        return {st, ireq, irwe, dreq, dwe, asb, rfwe, wbs, pcwe, pcs, ret, trp, flt};
    endfunction

    task automatic cyc(input logic r, input logic imr, input logic dmr, input logic [9:0] fl,
                       input logic bt, input obs_t e, input string nm);
        @(posedge clk);
        #1;
        rst          = r;
        imem_ready   = imr;
        dmem_ready   = dmr;
        {is_r_type, is_i_type, is_s_type, is_b_type, is_u_type, is_j_type,
         is_fence_type, is_system_type, is_load, is_jalr} = fl;
        branch_taken = bt;
        if (r) exp_ret = 32'd0;
        q.push_back('{o: e, n: exp_ret});
        nq.push_back(nm);
        if (e.ret) exp_ret = exp_ret + 32'd1;
    endtask

    task automatic fd(input logic [9:0] fl);
        cyc(1'b0, 1'b1, 1'b1, fl, 1'b0, ob(3'd1, 1,1,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "fetch");
        cyc(1'b0, 1'b1, 1'b1, fl, 1'b0, ob(3'd2, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "decode");
    endtask

    task automatic ex(input logic [9:0] fl, input logic asb, input string nm);
        cyc(1'b0, 1'b1, 1'b1, fl, 1'b0, ob(3'd3, 0,0,0,0,asb,0, 2'd0, 0, 2'd0, 0,0,0), nm);
    endtask

    task automatic wb(input logic [9:0] fl, input logic [1:0] wbs, input logic [1:0] pcs, input string nm);
        cyc(1'b0, 1'b1, 1'b1, fl, 1'b0, ob(3'd5, 0,0,0,0,0,1, wbs, 1, pcs, 1,0,0), nm);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            mn = nq.pop_front();
            checks++;
            if (act !== me.o || instret !== me.n) begin
                errors++;
                $display("FAIL %s: got strobes %b instret %0d, expected strobes %b instret %0d",
                         mn, act, instret, me.o, me.n);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        {is_r_type, is_i_type, is_s_type, is_b_type, is_u_type, is_j_type,
         is_fence_type, is_system_type, is_load, is_jalr} = FL_NONE;
        repeat (2) @(posedge clk);
        cyc(1, 0, 0, FL_NONE, 0, ob(3'd0, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "reset_hold");
        cyc(0, 0, 0, FL_NONE, 0, ob(3'd0, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "idle_release");

        fd(FL_R); ex(FL_R, 0, "r_execute"); wb(FL_R, 2'd0, 2'd0, "r_writeback");

        fd(FL_LD); ex(FL_LD, 1, "ld_execute");
        repeat (3) cyc(0, 1, 0, FL_LD, 0, ob(3'd4, 0,0,1,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "ld_mem_wait");
        cyc(0, 1, 1, FL_LD, 0, ob(3'd4, 0,0,1,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "ld_mem_ready");
        wb(FL_LD, 2'd1, 2'd0, "ld_writeback");

        fd(FL_B); cyc(0, 1, 1, FL_B, 1, ob(3'd3, 0,0,0,0,0,0, 2'd0, 1, 2'd1, 1,0,0), "br_taken");
        fd(FL_B); cyc(0, 1, 1, FL_B, 0, ob(3'd3, 0,0,0,0,0,0, 2'd0, 1, 2'd0, 1,0,0), "br_not_taken");

        fd(FL_JALR); ex(FL_JALR, 1, "jalr_execute"); wb(FL_JALR, 2'd2, 2'd2, "jalr_writeback");
        fd(FL_J);    ex(FL_J, 1, "jal_execute");     wb(FL_J, 2'd2, 2'd1, "jal_writeback");

        repeat (2) cyc(0, 0, 1, FL_U, 0, ob(3'd1, 1,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "fetch_wait");
        fd(FL_U); ex(FL_U, 1, "u_execute"); wb(FL_U, 2'd0, 2'd0, "u_writeback");
        fd(FL_I); ex(FL_I, 1, "i_execute"); wb(FL_I, 2'd0, 2'd0, "i_writeback");

        fd(FL_F); cyc(0, 1, 1, FL_F, 0, ob(3'd3, 0,0,0,0,0,0, 2'd0, 1, 2'd0, 1,0,0), "fence_nop");
        fd(FL_SYS);
`ifdef MULTICYCLE_CTRL_TRAP_EN
        ex(FL_SYS, 0, "sys_execute");
        cyc(0, 1, 1, FL_SYS, 0, ob(3'd6, 0,0,0,0,0,0, 2'd0, 1, 2'd3, 0,1,0), "sys_trap");
`else
        cyc(0, 1, 1, FL_SYS, 0, ob(3'd3, 0,0,0,0,0,0, 2'd0, 1, 2'd0, 1,0,0), "sys_nop");
`endif

        fd(FL_S); ex(FL_S, 1, "st_execute");
        repeat (3) cyc(0, 1, 0, FL_S, 0, ob(3'd4, 0,0,1,1,0,0, 2'd0, 0, 2'd0, 0,0,0), "st_mem_wait");
        cyc(0, 1, 1, FL_S, 0, ob(3'd4, 0,0,1,1,0,0, 2'd0, 1, 2'd0, 1,0,0), "st_ready_at_limit");

        fd(FL_S); ex(FL_S, 1, "st2_execute");
        cyc(0, 1, 0, FL_S, 0, ob(3'd4, 0,0,1,1,0,0, 2'd0, 0, 2'd0, 0,0,0), "pre_reset_mem");
        cyc(1, 1, 0, FL_S, 0, ob(3'd0, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "async_reset_in_mem");
        cyc(0, 1, 1, FL_S, 0, ob(3'd0, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "idle_after_reset");

        fd(FL_S); ex(FL_S, 1, "st3_execute");
        repeat (4) cyc(0, 1, 0, FL_S, 0, ob(3'd4, 0,0,1,1,0,0, 2'd0, 0, 2'd0, 0,0,0), "st_timeout_wait");
        repeat (2) cyc(0, 1, 1, FL_S, 0, ob(3'd7, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,1), "timeout_fault_sticky");

        cyc(1, 1, 1, FL_NONE, 0, ob(3'd0, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "reset_from_fault");
        cyc(0, 1, 1, FL_NONE, 0, ob(3'd0, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "idle_again");
        fd(FL_NONE);
`ifdef MULTICYCLE_CTRL_TRAP_EN
        cyc(0, 1, 1, FL_NONE, 0, ob(3'd6, 0,0,0,0,0,0, 2'd0, 1, 2'd3, 0,1,0), "illegal_trap");
        cyc(0, 1, 1, FL_RI, 0, ob(3'd1, 1,1,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "fetch_after_trap");
        cyc(0, 1, 1, FL_RI, 0, ob(3'd2, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "decode_multi");
        cyc(0, 1, 1, FL_RI, 0, ob(3'd6, 0,0,0,0,0,0, 2'd0, 1, 2'd3, 0,1,0), "multi_flag_trap");
`else
        repeat (2) cyc(0, 1, 1, FL_NONE, 0, ob(3'd7, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,1), "illegal_fault");
        cyc(1, 1, 1, FL_NONE, 0, ob(3'd0, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "reset_again");
        cyc(0, 1, 1, FL_RI, 0, ob(3'd0, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,0), "idle_multi");
        fd(FL_RI);
        cyc(0, 1, 1, FL_RI, 0, ob(3'd7, 0,0,0,0,0,0, 2'd0, 0, 2'd0, 0,0,1), "multi_flag_fault");
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Consumes the one-hot instruction-class flags from the opcode decoder plus load/JALR qualifiers.
- Sequences fetch, decode, execute, memory and writeback, and drives all datapath strobes: PC, IR, register file, memory, writeback mux.
- Handles the imem/dmem ready handshakes with a timeout watchdog and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before FAULT; 0 disables the watchdog.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- is_r_type, is_i_type, is_s_type, is_b_type, is_u_type, is_j_type, is_fence_type, is_system_type  in  1 each  decoder class flags
- is_load  in  1  opcode 0000011; valid with is_i_type
- is_jalr  in  1  opcode 1100111; valid with is_i_type
- branch_taken  in  1  comparator result, valid in EXECUTE
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid
- ir_we  out  1  instruction register load
- dmem_req  out  1  data memory request
- dmem_we  out  1  store enable, qualifies dmem_req
- dmem_ready  in  1  data access complete
- alu_src_b  out  1  0 = rs2, 1 = immediate
- rf_we  out  1  register file write
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4
- pc_we  out  1  PC update
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = rs1+imm (JALR), 3 = trap vector
- retire  out  1  one-cycle pulse per retired instruction
- trap  out  1  trap pulse (optional feature)
- fault  out  1  sticky fault
- state  out  3  0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE, 4 MEM, 5 WRITEBACK, 6 TRAP, 7 FAULT
- instret  out  INSTRET_W  retired-instruction count

Behaviour:
- State register and latched class flags are the only control registers.
- All strobes are combinational from state, latched flags and ready inputs. All strobes are 0 in IDLE and FAULT.
- Reset (any time, including mid-transaction): state=IDLE, latched flags=0, instret=0, timeout counter=0. All outputs 0.
- IDLE -> FETCH unconditionally on the first clock after rst deasserts.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_we=1 in the same cycle, then -> DECODE.
- DECODE:
  - One cycle. Latch all class flags plus is_load/is_jalr.
  - Exactly one class flag set -> EXECUTE.
  - Zero or more than one flag set = illegal -> FAULT.
- EXECUTE:
  - alu_src_b=1 for I/S/U/J classes.
  - B-type: pc_we=1, pc_sel=branch_taken?1:0, retire=1, then -> FETCH.
  - Load or S-type -> MEM.
  - FENCE, SYSTEM: treated as NOP; pc_we=1, pc_sel=0, retire=1, then -> FETCH.
  - R, I (non-load), U, J, JALR -> WRITEBACK.
- MEM:
  - dmem_req=1; dmem_we=latched is_s_type.
  - On dmem_ready with a store: pc_we=1, pc_sel=0, retire=1, then -> FETCH.
  - On dmem_ready with a load: -> WRITEBACK.
- WRITEBACK:
  - rf_we=1, pc_we=1, retire=1, then -> FETCH.
  - wb_sel: 2 for J/JALR, 1 for load, else 0.
  - pc_sel: 1 for J, 2 for JALR, else 0.
- Watchdog:
  - Counter clears on entry to FETCH/MEM and increments each cycle with req=1 and ready=0.
  - If it reaches MEM_TIMEOUT with ready still 0 -> FAULT.
  - Ready arriving in the same cycle as the limit wins; no fault.
- FAULT: absorbing; fault=1 until reset.
- instret increments on every retire cycle and wraps modulo 2^INSTRET_W.
- Minimum latencies with ready already high:
  - Branch / FENCE / SYSTEM: 3 cycles.
  - ALU op: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TRAP_EN.
- Defined:
  - Illegal class, and SYSTEM in EXECUTE, -> TRAP.
  - TRAP is one cycle: trap=1, pc_we=1, pc_sel=3, retire=0, then -> FETCH.
  - FAULT is reached only via the watchdog.
- Undefined:
  - TRAP state is unreachable and trap is tied to 0.
  - Illegal class -> FAULT; SYSTEM is a NOP.

Test Plan:
- Reset, then R-type (0110011 flags), imem_ready/dmem_ready held 1 -> state 0,1,2,3,5,1. rf_we=1, wb_sel=0, pc_sel=0 in WRITEBACK. instret=1 after 4 cycles.
- Load with dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles. Then WRITEBACK with wb_sel=1. Total 8 cycles from FETCH to next FETCH.
- Branch: taken -> pc_sel=1, then not-taken -> pc_sel=0, both in EXECUTE. JALR -> WRITEBACK with wb_sel=2, pc_sel=2. instret=3.
- MEM_TIMEOUT=4, store with dmem_ready stuck 0 -> FAULT after 4 waiting cycles; fault=1 held. Variant with ready in the 4th wait cycle -> no fault.
- Decode flags all 0 -> FAULT (macro off). With macro on -> trap=1 for one cycle, pc_sel=3, retire=0, then FETCH.
- Assert rst in MEM with dmem_req=1 -> dmem_req drops immediately (async). state=0, instret=0, then FETCH one cycle after release.
